// File: rtl/bus_arbiter_nx1.sv
// bus_arbiter_nx1: N-master to 1-slave round-robin bus arbiter
// holds each grant until the slave acks, with an optional hung-transfer timeout
module bus_arbiter_nx1 #(
  parameter int N_MASTERS = 4,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int TIMEOUT   = 0
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [N_MASTERS-1:0]        i_bus_en,
  input  logic [N_MASTERS-1:0]        i_wr_rd,
  input  logic [N_MASTERS*DATA_W-1:0] i_wr_data,
  input  logic [N_MASTERS*ADDR_W-1:0] i_addr,
  input  logic [N_MASTERS*3-1:0]      i_size,
  output logic [N_MASTERS-1:0]        o_ack,
  output logic [N_MASTERS-1:0]        o_err,
  output logic [N_MASTERS*DATA_W-1:0] o_rd_data,
  input  logic                        i_ack,
  input  logic [DATA_W-1:0]           i_rd_data,
  output logic                        o_bus_en,
  output logic                        o_wr_rd,
  output logic [DATA_W-1:0]           o_wr_data,
  output logic [ADDR_W-1:0]           o_addr,
  output logic [2:0]                  o_size,
  output logic [N_MASTERS-1:0]        o_grant,
  output logic                        o_busy
);
  localparam int IDX_W = $clog2(N_MASTERS);
  localparam int TMO_W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] gnt_idx, gnt_n, ptr, ptr_n, winner, cand, gnt_inc;
  logic [TMO_W-1:0] tmo_cnt, tmo_n;
  logic             busy, tmo_hit, done;

  // scan downwards so the request closest to ptr is the last one to win
  always_comb begin
    winner = '0;
    cand   = '0;
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(ptr) + k) % N_MASTERS);
      if (i_bus_en[cand]) winner = cand;
    end
  end

  // outputs are forced idle while reset is held, even mid-transfer
  assign busy    = (state == BUSY) && !i_rst;
  assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign done    = i_ack || tmo_hit;
  assign gnt_inc = (gnt_idx == IDX_W'(N_MASTERS - 1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    state_n = state;
    gnt_n   = gnt_idx;
    ptr_n   = ptr;
    tmo_n   = tmo_cnt + 1'b1;
    if (state == IDLE) begin
      tmo_n   = '0;
      state_n = |i_bus_en ? BUSY : IDLE;
      gnt_n   = |i_bus_en ? winner : gnt_idx;
    end else if (done) begin
      state_n = IDLE;
      ptr_n   = gnt_inc;
    end else if (!i_bus_en[gnt_idx]) begin
      state_n = IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      gnt_idx <= '0;
      ptr     <= '0;
      tmo_cnt <= '0;
    end else begin
      state   <= state_n;
      gnt_idx <= gnt_n;
      ptr     <= ptr_n;
      tmo_cnt <= tmo_n;
    end
  end

  always_comb begin
    o_bus_en  = busy && i_bus_en[gnt_idx];
    o_wr_rd   = busy && i_wr_rd[gnt_idx];
    o_wr_data = busy ? i_wr_data[gnt_idx*DATA_W +: DATA_W] : '0;
    o_addr    = busy ? i_addr[gnt_idx*ADDR_W +: ADDR_W] : '0;
    o_size    = busy ? i_size[gnt_idx*3 +: 3] : '0;
    o_grant   = '0;
    o_ack     = '0;
    o_err     = '0;
    o_rd_data = '0;
    if (busy) begin
      o_grant[gnt_idx]                      = 1'b1;
      o_ack[gnt_idx]                        = done;
      o_err[gnt_idx]                        = tmo_hit && !i_ack;
      o_rd_data[gnt_idx*DATA_W +: DATA_W]   = i_rd_data;
    end
  end

  assign o_busy = busy;
endmodule

// File: tb/tb_bus_arbiter_nx1.sv
// tb_bus_arbiter_nx1: directed + randomized check of bus_arbiter_nx1 against a transfer-level model
module tb_bus_arbiter_nx1;
  localparam int N = 4, DW = 32, AW = 32, TMO = 8;

  logic clk = 0, rst = 1;
  always #5 clk = ~clk;

  logic [N-1:0]    bus_en = '1, wr_rd = '0, ack_o, err_o, grant;
  logic [N*DW-1:0] wr_data = '0, rd_data_o;
  logic [N*AW-1:0] addr = '0;
  logic [N*3-1:0]  size = '0;
  logic            s_ack = 0, s_en, s_wr, busy;
  logic [DW-1:0]   s_rd = '0, s_wd;
  logic [AW-1:0]   s_addr;
  logic [2:0]      s_size;

  bus_arbiter_nx1 #(.N_MASTERS(N), .DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst(rst), .i_bus_en(bus_en), .i_wr_rd(wr_rd), .i_wr_data(wr_data),
    .i_addr(addr), .i_size(size), .o_ack(ack_o), .o_err(err_o), .o_rd_data(rd_data_o),
    .i_ack(s_ack), .i_rd_data(s_rd), .o_bus_en(s_en), .o_wr_rd(s_wr), .o_wr_data(s_wd),
    .o_addr(s_addr), .o_size(s_size), .o_grant(grant), .o_busy(busy)
  );

  int tests = 0, fails = 0;

  task automatic chk(string tag, logic [255:0] got, logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // transfer-level model: owner of the bus, rotating priority start, cycles spent on the transfer
  bit m_busy = 0;
  int m_g = 0, m_ptr = 0, m_cnt = 0;

  logic [N-1:0]    obs_grant, obs_ack, obs_err, exp_ack;
  logic [N*DW-1:0] obs_rd;
  logic [AW-1:0]   obs_addr;

  task automatic step();
    logic [N-1:0]    e_ack, e_err, e_grant;
    logic [N*DW-1:0] e_rd;
    logic            e_en, e_wr;
    logic [DW-1:0]   e_wd;
    logic [AW-1:0]   e_addr;
    logic [2:0]      e_size;
    bit              hit, found;
    @(negedge clk);
    e_ack = '0; e_err = '0; e_grant = '0; e_rd = '0;
    e_en = 0; e_wr = 0; e_wd = '0; e_addr = '0; e_size = '0;
    if (!rst && m_busy) begin
      hit = (m_cnt == TMO - 1);
      e_grant[m_g] = 1;
      e_en   = bus_en[m_g];
      e_wr   = wr_rd[m_g];
      e_wd   = wr_data[m_g*DW +: DW];
      e_addr = addr[m_g*AW +: AW];
      e_size = size[m_g*3 +: 3];
      e_ack[m_g] = s_ack || hit;
      e_err[m_g] = !s_ack && hit;
      e_rd[m_g*DW +: DW] = s_rd;
    end
    chk("grant", grant, e_grant);
    chk("busy", busy, !rst && m_busy);
    chk("bus_en", s_en, e_en);
    chk("wr_rd", s_wr, e_wr);
    chk("wr_data", s_wd, e_wd);
    chk("addr", s_addr, e_addr);
    chk("size", s_size, e_size);
    chk("ack", ack_o, e_ack);
    chk("err", err_o, e_err);
    chk("rd_data", rd_data_o, e_rd);
    obs_grant = grant; obs_ack = ack_o; obs_err = err_o; obs_rd = rd_data_o; obs_addr = s_addr;
    exp_ack = e_ack;
    @(posedge clk);
    if (rst) begin
      m_busy = 0; m_ptr = 0; m_cnt = 0;
    end else if (!m_busy) begin
      found = 0;
      for (int k = 0; k < N; k++)
        if (!found && bus_en[(m_ptr + k) % N]) begin
          found = 1;
          m_g = (m_ptr + k) % N;
        end
      m_busy = found;
      m_cnt = 0;
    end else if (e_ack[m_g]) begin
      m_busy = 0;
      m_ptr = (m_g + 1) % N;
    end else if (!bus_en[m_g]) m_busy = 0;
    else m_cnt++;
    #1;
  endtask

  task automatic rnd_req(int m);
    bus_en[m] = 1;
    wr_rd[m] = 1'($urandom % 2);
    wr_data[m*DW +: DW] = $urandom;
    addr[m*AW +: AW] = $urandom;
    size[m*3 +: 3] = 3'($urandom % 8);
  endtask

  int seen[$];
  logic [N*DW-1:0] exp_rd;

  initial begin
    repeat (3) step();
    chk("rst_grant", obs_grant, 0);
    chk("rst_ack", obs_ack, 0);
    rst = 0; s_ack = 1;
    step();
    chk("rst_idle_grant", obs_grant, 0);
    for (int i = 0; i < 9; i++) begin
      step();
      if (obs_grant != 0) seen.push_back($clog2(obs_grant));
    end
    chk("rr_count", seen.size(), 5);
    for (int i = 0; i < 5 && i < seen.size(); i++) chk("rr_order", seen[i], i % N);
    bus_en = '0; s_ack = 0;
    step();
    bus_en = 4'b0010; s_ack = 1;
    repeat (2) step();
    bus_en = 4'b1001;
    step();
    step();
    chk("cont_first", obs_grant, 4'b1000);
    bus_en = 4'b0001;
    step();
    step();
    chk("cont_second", obs_grant, 4'b0001);
    bus_en = '0; s_ack = 0;
    step();
    bus_en = 4'b0100; wr_rd = '0; addr[2*AW +: AW] = 32'h100;
    repeat (3) step();
    s_ack = 1; s_rd = 32'hDEADBEEF;
    step();
    exp_rd = '0; exp_rd[2*DW +: DW] = 32'hDEADBEEF;
    chk("single_addr", obs_addr, 32'h100);
    chk("single_ack", obs_ack, 4'b0100);
    chk("single_rd", obs_rd, exp_rd);
    bus_en = '0; s_ack = 0;
    step();
    bus_en = 4'b0010;
    step();
    for (int i = 1; i <= TMO; i++) begin
      step();
      if (i < TMO) chk("tmo_early_ack", obs_ack, 0);
    end
    chk("tmo_ack", obs_ack, 4'b0010);
    chk("tmo_err", obs_err, 4'b0010);
    bus_en = '0; s_ack = 1;
    step();
    chk("late_ack", obs_ack, 0);
    s_ack = 0; bus_en = 4'b0001;
    repeat (2) step();
    bus_en = '0;
    step();
    chk("abort_ack", obs_ack, 0);
    step();
    chk("abort_idle", obs_grant, 0);
    bus_en = 4'b1001;
    repeat (2) step();
    chk("abort_ptr", obs_grant, 4'b1000);
    rst = 1;
    step();
    chk("rst_mid_grant", obs_grant, 0);
    rst = 0; bus_en = '0;
    step();
    chk("rst_after_grant", obs_grant, 0);
    for (int c = 0; c < 3000; c++) begin
      for (int m = 0; m < N; m++)
        if (!bus_en[m]) begin
          if ($urandom % 4 == 0) rnd_req(m);
        end else if ($urandom % 64 == 0) bus_en[m] = 0;
      s_ack = ($urandom % 3 == 0);
      s_rd = $urandom;
      rst = ($urandom % 500 == 0);
      step();
      for (int m = 0; m < N; m++) if (exp_ack[m]) bus_en[m] = 0;
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
